// File: rtl/mp_shared_memory.sv
// mp_shared_memory: multi-port shared word memory with a request/ack handshake,
// registered reads that also return the line tag, and rotating-priority
// arbitration between ports that write the same address in the same cycle.
module mp_shared_memory #(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 4,
  parameter int TAG_W     = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_PORTS-1:0]        req,
  input  logic [NUM_PORTS-1:0]        we,
  input  logic [NUM_PORTS*ADDR_W-1:0] addr,
  input  logic [NUM_PORTS*DATA_W-1:0] wdata,
  output logic [NUM_PORTS-1:0]        ack,
  output logic [NUM_PORTS-1:0]        rvalid,
  output logic [NUM_PORTS*DATA_W-1:0] rdata,
  output logic [NUM_PORTS*TAG_W-1:0]  rtag,
  output logic [15:0]                 conflict_cnt
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [DATA_W-1:0]    mem [DEPTH];
  logic [PTR_W-1:0]     rr_ptr;
  logic [NUM_PORTS-1:0] is_rd;
  logic [NUM_PORTS-1:0] is_wr;
  logic [NUM_PORTS-1:0] wr_grant;
  logic                 any_denied;

  // Word loaded into location idx on reset; the top two locations override
  // the low ones when the memory is very shallow.
  function automatic logic [DATA_W-1:0] boot_value(input int idx);
    logic [DATA_W-1:0] val;
    val = '0;
    if (idx == 4) val = DATA_W'(1);
    if (idx == 5) val = DATA_W'(3);
    if (idx == DEPTH - 2) val = DATA_W'(7);
    if (idx == DEPTH - 1) val = DATA_W'(15);
    return val;
  endfunction

  // Priority rank of a port relative to the rotating pointer (0 = highest).
  function automatic int prio_dist(input int idx, input int ptr);
    return (idx >= ptr) ? (idx - ptr) : (idx + NUM_PORTS - ptr);
  endfunction

  assign is_rd = req & ~we;
  assign is_wr = req & we;

  // A writer is granted unless another writer to the same address ranks ahead of it.
  always_comb begin
    wr_grant = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (is_wr[p]) begin
        wr_grant[p] = 1'b1;
        for (int q = 0; q < NUM_PORTS; q++) begin
          if (q != p && is_wr[q] &&
              addr[q*ADDR_W +: ADDR_W] == addr[p*ADDR_W +: ADDR_W] &&
              prio_dist(q, int'(rr_ptr)) < prio_dist(p, int'(rr_ptr))) begin
            wr_grant[p] = 1'b0;
          end
        end
      end
    end
  end

  assign any_denied = |(is_wr & ~wr_grant);
  assign ack        = {NUM_PORTS{rst_n}} & (is_rd | wr_grant);

  // Memory array: boot image on reset, otherwise commit every granted write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= boot_value(i);
      end
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (wr_grant[p]) begin
          mem[addr[p*ADDR_W +: ADDR_W]] <= wdata[p*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Read pipeline: capture old memory contents and the address tag per port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid <= '0;
      rdata  <= '0;
      rtag   <= '0;
    end else begin
      rvalid <= is_rd;
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (is_rd[p]) begin
          rdata[p*DATA_W +: DATA_W] <= mem[addr[p*ADDR_W +: ADDR_W]];
          rtag[p*TAG_W +: TAG_W]    <= addr[p*ADDR_W + ADDR_W - 1 -: TAG_W];
        end
      end
    end
  end

  // Rotate priority and count conflict cycles whenever some writer lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr       <= '0;
      conflict_cnt <= '0;
    end else if (any_denied) begin
      if (rr_ptr == PTR_W'(NUM_PORTS - 1)) rr_ptr <= '0;
      else rr_ptr <= rr_ptr + 1'b1;
      if (conflict_cnt != 16'hFFFF) conflict_cnt <= conflict_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_mp_shared_memory.sv
// tb_mp_shared_memory: directed and randomized checks of mp_shared_memory
// against a cycle-level behavioural model of the shared memory.
module tb_mp_shared_memory;

  localparam int N     = 4;
  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int TW    = 2;
  localparam int DEPTH = 2 ** AW;

  logic              clk;
  logic              rst_n;
  logic [N-1:0]      req;
  logic [N-1:0]      we;
  logic [N*AW-1:0]   addr;
  logic [N*DW-1:0]   wdata;
  logic [N-1:0]      ack;
  logic [N-1:0]      rvalid;
  logic [N*DW-1:0]   rdata;
  logic [N*TW-1:0]   rtag;
  logic [15:0]       conflict_cnt;

  int num_checks;
  int num_errors;

  // Reference model state
  logic [DW-1:0] m_mem [DEPTH];
  int            m_rr;
  int            m_cnt;
  logic [N-1:0]  m_rvalid;
  logic [DW-1:0] m_rdata [N];
  logic [TW-1:0] m_rtag [N];
  logic [N-1:0]  last_ack;

  mp_shared_memory #(.NUM_PORTS(N), .DATA_W(DW), .ADDR_W(AW), .TAG_W(TW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .we           (we),
    .addr         (addr),
    .wdata        (wdata),
    .ack          (ack),
    .rvalid       (rvalid),
    .rdata        (rdata),
    .rtag         (rtag),
    .conflict_cnt (conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    num_checks++;
    if (obs !== exp) begin
      num_errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    m_mem[4] = 1;
    m_mem[5] = 3;
    m_mem[DEPTH-2] = 7;
    m_mem[DEPTH-1] = 15;
    m_rr = 0;
    m_cnt = 0;
    m_rvalid = '0;
    for (int p = 0; p < N; p++) begin
      m_rdata[p] = '0;
      m_rtag[p] = '0;
    end
  endtask

  function automatic int portAddr(input logic [N*AW-1:0] a, input int p);
    return int'(a[p*AW +: AW]);
  endfunction

  task automatic checkRegs(input string tag);
    checkOutput({tag, "_rvalid"}, rvalid, m_rvalid);
    checkOutput({tag, "_cnt"}, conflict_cnt, m_cnt);
    for (int p = 0; p < N; p++) begin
      checkOutput($sformatf("%s_rdata%0d", tag, p), rdata[p*DW +: DW], m_rdata[p]);
      checkOutput($sformatf("%s_rtag%0d", tag, p), rtag[p*TW +: TW], m_rtag[p]);
    end
  endtask

  // One clock cycle of traffic: drive, check ack, clock, advance model, check registers.
  task automatic applyStimulus(input logic [N-1:0] r, input logic [N-1:0] w,
                               input logic [N*AW-1:0] a, input logic [N*DW-1:0] d,
                               input bit do_check, input string tag);
    logic [N-1:0]  exp_ack;
    logic [N-1:0]  new_rvalid;
    bit            denied;
    logic [DW-1:0] snap [DEPTH];
    req = r; we = w; addr = a; wdata = d;
    #1;
    exp_ack = '0;
    denied = 0;
    new_rvalid = '0;
    for (int i = 0; i < DEPTH; i++) snap[i] = m_mem[i];
    for (int p = 0; p < N; p++) begin
      if (r[p] && !w[p]) begin
        exp_ack[p] = 1'b1;
        new_rvalid[p] = 1'b1;
      end else if (r[p] && w[p]) begin
        int winner;
        winner = -1;
        for (int k = 0; k < N; k++) begin
          int idx;
          idx = (m_rr + k) % N;
          if (winner < 0 && r[idx] && w[idx] && portAddr(a, idx) == portAddr(a, p)) winner = idx;
        end
        if (winner == p) exp_ack[p] = 1'b1;
        else denied = 1;
      end
    end
    last_ack = ack;
    if (do_check) checkOutput({tag, "_ack"}, ack, exp_ack);
    @(posedge clk);
    #1;
    for (int p = 0; p < N; p++) begin
      if (new_rvalid[p]) begin
        m_rdata[p] = snap[portAddr(a, p)];
        m_rtag[p] = TW'(portAddr(a, p) / (2 ** (AW - TW)));
      end
      if (r[p] && w[p] && exp_ack[p]) m_mem[portAddr(a, p)] = d[p*DW +: DW];
    end
    m_rvalid = new_rvalid;
    if (denied) begin
      m_rr = (m_rr + 1) % N;
      if (m_cnt < 65535) m_cnt++;
    end
    if (do_check) checkRegs(tag);
  endtask

  task automatic idle();
    applyStimulus('0, '0, '0, '0, 1'b1, "idle");
  endtask

  initial begin
    logic [N*AW-1:0] a;
    logic [N*DW-1:0] d;
    logic [N-1:0]    r;
    logic [N-1:0]    w;
    num_checks = 0;
    num_errors = 0;
    req = '0; we = '0; addr = '0; wdata = '0;
    rst_n = 1'b0;
    modelReset();
    #23;
    checkOutput("rst_ack", ack, 0);
    checkRegs("rst");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Boot image read: P0 addr 5, P1 addr 15
    a = '0; a[0*AW +: AW] = 5; a[1*AW +: AW] = 15;
    applyStimulus(4'b0011, 4'b0000, a, '0, 1'b1, "boot");
    checkOutput("boot_ack_c", last_ack, 4'b0011);
    checkOutput("boot_rdata0_c", rdata[0 +: DW], 3);
    checkOutput("boot_rtag1_c", rtag[TW +: TW], 3);

    // Parallel writes to distinct addresses, then read back
    a = '0; d = '0;
    for (int p = 0; p < N; p++) begin
      a[p*AW +: AW] = AW'(p);
      d[p*DW +: DW] = DW'(32'hA0 + p);
    end
    applyStimulus(4'b1111, 4'b1111, a, d, 1'b1, "par_wr");
    checkOutput("par_wr_ack_c", last_ack, 4'b1111);
    applyStimulus(4'b1111, 4'b0000, a, '0, 1'b1, "par_rd");
    checkOutput("par_rd_rdata3_c", rdata[3*DW +: DW], 32'hA3);

    // Three-way collision on addr 9 with held requests
    a = '0; d = '0;
    for (int p = 0; p < N; p++) a[p*AW +: AW] = 9;
    d[0*DW +: DW] = 32'h11; d[2*DW +: DW] = 32'h22; d[3*DW +: DW] = 32'h33;
    applyStimulus(4'b1101, 4'b1101, a, d, 1'b1, "coll1");
    checkOutput("coll1_ack_c", last_ack, 4'b0001);
    applyStimulus(4'b1100, 4'b1100, a, d, 1'b1, "coll2");
    checkOutput("coll2_ack_c", last_ack, 4'b0100);
    applyStimulus(4'b1000, 4'b1000, a, d, 1'b1, "coll3");
    checkOutput("coll3_ack_c", last_ack, 4'b1000);
    checkOutput("coll_cnt_c", conflict_cnt, 2);
    applyStimulus(4'b0001, 4'b0000, a, '0, 1'b1, "coll_rd");
    checkOutput("coll_mem9_c", rdata[0 +: DW], 32'h33);

    // Same-cycle read and write to addr 4: read returns old data
    a = '0; d = '0;
    a[0*AW +: AW] = 4; a[1*AW +: AW] = 4; d[1*DW +: DW] = 32'h55;
    applyStimulus(4'b0011, 4'b0010, a, d, 1'b1, "rw_same");
    checkOutput("rw_old_c", rdata[0 +: DW], 1);
    applyStimulus(4'b0001, 4'b0000, a, '0, 1'b1, "rw_next");
    checkOutput("rw_new_c", rdata[0 +: DW], 32'h55);

    // Randomized traffic concentrated on a few addresses to provoke collisions
    for (int c = 0; c < 400; c++) begin
      r = N'($urandom);
      w = N'($urandom);
      for (int p = 0; p < N; p++) begin
        a[p*AW +: AW] = AW'($urandom_range(0, 3) + ((c % 4 == 0) ? 12 : 0));
        d[p*DW +: DW] = $urandom;
      end
      applyStimulus(r, w, a, d, 1'b1, "rand");
    end

    // Saturation: sustained collision until conflict_cnt pins at 0xFFFF
    a = '0; d = '0;
    a[0*AW +: AW] = 7; a[1*AW +: AW] = 7;
    d[0*DW +: DW] = 32'h70; d[1*DW +: DW] = 32'h71;
    for (int c = 0; c < 65540; c++) applyStimulus(4'b0011, 4'b0011, a, d, 1'b0, "sat");
    checkOutput("sat_cnt_c", conflict_cnt, 16'hFFFF);
    applyStimulus(4'b0011, 4'b0011, a, d, 1'b1, "sat_hold");
    checkOutput("sat_hold_c", conflict_cnt, 16'hFFFF);

    // Reset mid-collision with a read in flight
    a = '0; a[2*AW +: AW] = 5;
    applyStimulus(4'b0100, 4'b0000, a, '0, 1'b1, "pre_rst");
    a = '0; d = '0;
    a[0*AW +: AW] = 9; a[1*AW +: AW] = 9;
    d[0*DW +: DW] = 32'hEE; d[1*DW +: DW] = 32'hEF;
    req = 4'b0011; we = 4'b0011; addr = a; wdata = d;
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput("midrst_ack", ack, 0);
    checkOutput("midrst_rvalid", rvalid, 0);
    checkOutput("midrst_cnt", conflict_cnt, 0);
    @(posedge clk);
    #3;
    req = '0; we = '0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkRegs("post_rst");
    a = '0; a[0*AW +: AW] = 4; a[1*AW +: AW] = 9;
    applyStimulus(4'b0011, 4'b0000, a, '0, 1'b1, "post_rst_rd");
    checkOutput("post_rst_mem4_c", rdata[0 +: DW], 1);
    checkOutput("post_rst_mem9_c", rdata[DW +: DW], 0);
    a = '0; a[0*AW +: AW] = 3; a[1*AW +: AW] = 3;
    applyStimulus(4'b0011, 4'b0011, a, d, 1'b1, "post_rst_rr");
    checkOutput("post_rst_rr_c", last_ack, 4'b0001);
    idle();

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule
